// File: rtl/pipe_regs_fde_pkg.sv
// Shared constants, control-bundle layout and stage payload types for the
// RV32I fetch/decode/execute pipeline registers.
package rv32_pipe_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CTRL_W = 10;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

   // Bit offsets inside CtrlD/CtrlE: {RegWrite,ResultSrc[1:0],MemWrite,Jump,Branch,ALUControl[2:0],ALUSrc}
   localparam int unsigned CTRL_ALUSRC    = 0;
   localparam int unsigned CTRL_ALUCTL    = 1;
   localparam int unsigned CTRL_BRANCH    = 4;
   localparam int unsigned CTRL_JUMP      = 5;
   localparam int unsigned CTRL_MEMWRITE  = 6;
   localparam int unsigned CTRL_RESULTSRC = 7;
   localparam int unsigned CTRL_REGWRITE  = 9;

   typedef enum logic [1:0] {
      RES_ALU  = 2'b00,
      RES_LOAD = 2'b01,
      RES_PC4  = 2'b10,
      RES_UIMM = 2'b11
   } result_src_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic            valid;
   } d_meta_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc_plus4;
      logic              valid;
   } e_stage_t;

   function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/pipe_regs_fde_if.sv
// Hazard-unit / decode-side bundle of the fetch/decode/execute pipeline registers.
interface pipe_regs_fde_if #(
   parameter int unsigned CNT_W = 32
);
   logic        StallF_i;
   logic        StallD_i;
   logic        FlushD_i;
   logic        FlushE_i;
   logic        PC_SrcE_i;
   logic [31:0] PC_TargetE_i;
   logic [31:0] InstrF_i;
   logic [9:0]  CtrlD_i;
   logic [31:0] RD1D_i;
   logic [31:0] RD2D_i;
   logic [31:0] ImmExtD_i;
   logic [4:0]  RS_addrD_i;
   logic [4:0]  RT_addrD_i;
   logic [4:0]  RD_addrD_i;

   logic [31:0] PCF_o;
   logic [31:0] InstrD_o;
   logic [31:0] PCD_o;
   logic [31:0] PCPlus4D_o;
   logic [9:0]  CtrlE_o;
   logic [31:0] RD1E_o;
   logic [31:0] RD2E_o;
   logic [31:0] ImmExtE_o;
   logic [31:0] PCE_o;
   logic [31:0] PCPlus4E_o;
   logic [4:0]  RS_addrE_o;
   logic [4:0]  RT_addrE_o;
   logic [4:0]  RD_addrE_o;
   logic        ValidD_o;
   logic        ValidE_o;
   logic [CNT_W-1:0] StallCnt_o;
   logic [CNT_W-1:0] FlushCnt_o;

   modport master (
      output StallF_i, StallD_i, FlushD_i, FlushE_i, PC_SrcE_i, PC_TargetE_i, InstrF_i,
             CtrlD_i, RD1D_i, RD2D_i, ImmExtD_i, RS_addrD_i, RT_addrD_i, RD_addrD_i,
      input  PCF_o, InstrD_o, PCD_o, PCPlus4D_o, CtrlE_o, RD1E_o, RD2E_o, ImmExtE_o,
             PCE_o, PCPlus4E_o, RS_addrE_o, RT_addrE_o, RD_addrE_o, ValidD_o, ValidE_o,
             StallCnt_o, FlushCnt_o
   );

   modport slave (
      input  StallF_i, StallD_i, FlushD_i, FlushE_i, PC_SrcE_i, PC_TargetE_i, InstrF_i,
             CtrlD_i, RD1D_i, RD2D_i, ImmExtD_i, RS_addrD_i, RT_addrD_i, RD_addrD_i,
      output PCF_o, InstrD_o, PCD_o, PCPlus4D_o, CtrlE_o, RD1E_o, RD2E_o, ImmExtE_o,
             PCE_o, PCPlus4E_o, RS_addrE_o, RT_addrE_o, RD_addrE_o, ValidD_o, ValidE_o,
             StallCnt_o, FlushCnt_o
   );

endinterface

// File: rtl/pipe_regs_fde_pipe_reg.sv
// Generic pipeline register: async reset and sync clear both load CLR_VAL; clear beats enable.
module pipe_reg #(
   parameter int unsigned  W       = 32,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)   r_q <= CLR_VAL;
      else if (i_clr) r_q <= CLR_VAL;
      else if (i_en)  r_q <= i_d;
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_regs_fde.sv
// PC, IF/ID and ID/EX registers of the RV32I core with stall/flush/redirect handling
// and saturating stall/flush event counters.
module pipe_regs_fde #(
   parameter logic [31:0] RESET_PC  = rv32_pipe_pkg::RESET_PC,
   parameter logic [31:0] NOP_INSTR = rv32_pipe_pkg::NOP_INSTR,
   parameter int unsigned CNT_W     = 32
) (
   input logic           clk_i,
   input logic           rst_n_i,
   pipe_regs_fde_if.slave bus
);
   import rv32_pipe_pkg::*;

   logic [XLEN-1:0] w_pcf;
   logic [XLEN-1:0] w_pcf_next;
   logic            w_pcf_en;
   logic [XLEN-1:0] w_instrd;
   d_meta_t         w_d_d;
   d_meta_t         w_d_q;
   e_stage_t        w_e_d;
   e_stage_t        w_e_q;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Redirect overrides StallF so a taken branch is never dropped.
   assign w_pcf_en   = bus.PC_SrcE_i | ~bus.StallF_i;
   assign w_pcf_next = bus.PC_SrcE_i ? bus.PC_TargetE_i : pc_plus4(w_pcf);

   pipe_reg #(.W(XLEN), .CLR_VAL(RESET_PC)) u_pc (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .i_en(w_pcf_en), .i_clr(1'b0),
      .i_d(w_pcf_next), .o_q(w_pcf)
   );

   pipe_reg #(.W(XLEN), .CLR_VAL(NOP_INSTR)) u_instr_d (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .i_en(~bus.StallD_i), .i_clr(bus.FlushD_i),
      .i_d(bus.InstrF_i), .o_q(w_instrd)
   );

   always_comb begin
      w_d_d          = '0;
      w_d_d.pc       = w_pcf;
      w_d_d.pc_plus4 = pc_plus4(w_pcf);
      w_d_d.valid    = 1'b1;
   end

   pipe_reg #(.W($bits(d_meta_t)), .CLR_VAL('0)) u_meta_d (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .i_en(~bus.StallD_i), .i_clr(bus.FlushD_i),
      .i_d(w_d_d), .o_q(w_d_q)
   );

   always_comb begin
      w_e_d          = '0;
      w_e_d.ctrl     = bus.CtrlD_i;
      w_e_d.rs       = bus.RS_addrD_i;
      w_e_d.rt       = bus.RT_addrD_i;
      w_e_d.rd       = bus.RD_addrD_i;
      w_e_d.rd1      = bus.RD1D_i;
      w_e_d.rd2      = bus.RD2D_i;
      w_e_d.imm      = bus.ImmExtD_i;
      w_e_d.pc       = w_d_q.pc;
      w_e_d.pc_plus4 = w_d_q.pc_plus4;
      w_e_d.valid    = w_d_q.valid;
   end

   // ID/EX has no stall: a zero bubble leaves RegWrite=0 and ResultSrc=ALU.
   pipe_reg #(.W($bits(e_stage_t)), .CLR_VAL('0)) u_stage_e (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .i_en(1'b1), .i_clr(bus.FlushE_i),
      .i_d(w_e_d), .o_q(w_e_q)
   );

   // Saturating event counters.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if ((bus.StallF_i | bus.StallD_i) && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if ((bus.FlushD_i | bus.FlushE_i) && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign bus.PCF_o      = w_pcf;
   assign bus.InstrD_o   = w_instrd;
   assign bus.PCD_o      = w_d_q.pc;
   assign bus.PCPlus4D_o = w_d_q.pc_plus4;
   assign bus.ValidD_o   = w_d_q.valid;
   assign bus.CtrlE_o    = w_e_q.ctrl;
   assign bus.RS_addrE_o = w_e_q.rs;
   assign bus.RT_addrE_o = w_e_q.rt;
   assign bus.RD_addrE_o = w_e_q.rd;
   assign bus.RD1E_o     = w_e_q.rd1;
   assign bus.RD2E_o     = w_e_q.rd2;
   assign bus.ImmExtE_o  = w_e_q.imm;
   assign bus.PCE_o      = w_e_q.pc;
   assign bus.PCPlus4E_o = w_e_q.pc_plus4;
   assign bus.ValidE_o   = w_e_q.valid;
   assign bus.StallCnt_o = r_stall_cnt;
   assign bus.FlushCnt_o = r_flush_cnt;

endmodule

// File: tb/tb_pipe_regs_fde.sv
// Directed bench for pipe_regs_fde: a behavioural model pushes expected stage
// contents per cycle; they are popped and compared after each rising edge.
module tb_pipe_regs_fde;
   import rv32_pipe_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_regs_fde_if #(.CNT_W(32)) bus ();
   pipe_regs_fde_if #(.CNT_W(4))  bus4 ();

   assign bus4.StallF_i     = bus.StallF_i;
   assign bus4.StallD_i     = bus.StallD_i;
   assign bus4.FlushD_i     = bus.FlushD_i;
   assign bus4.FlushE_i     = bus.FlushE_i;
   assign bus4.PC_SrcE_i    = bus.PC_SrcE_i;
   assign bus4.PC_TargetE_i = bus.PC_TargetE_i;
   assign bus4.InstrF_i     = bus.InstrF_i;
   assign bus4.CtrlD_i      = bus.CtrlD_i;
   assign bus4.RD1D_i       = bus.RD1D_i;
   assign bus4.RD2D_i       = bus.RD2D_i;
   assign bus4.ImmExtD_i    = bus.ImmExtD_i;
   assign bus4.RS_addrD_i   = bus.RS_addrD_i;
   assign bus4.RT_addrD_i   = bus.RT_addrD_i;
   assign bus4.RD_addrD_i   = bus.RD_addrD_i;

   pipe_regs_fde #(.CNT_W(32)) u_dut     (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
   pipe_regs_fde #(.CNT_W(4))  u_dut_sat (.clk_i(clk), .rst_n_i(rst_n), .bus(bus4));

   typedef struct packed {
      logic [31:0] pcf, instrd, pcd, pcp4d;
      logic        vd, ve;
      logic [9:0]  ctrle;
      logic [4:0]  rs, rt, rd;
      logic [31:0] rd1, rd2, imm, pce, pcp4e;
      logic [31:0] scnt, fcnt;
      logic [3:0]  scnt4, fcnt4;
   } exp_t;

   exp_t m;
   exp_t q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   bit   release_pending = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      m        = '0;
      m.pcf    = RESET_PC;
      m.instrd = NOP_INSTR;
   endtask

   task automatic check_all(input exp_t e);
      chk("PCF",      bus.PCF_o,       e.pcf);
      chk("InstrD",   bus.InstrD_o,    e.instrd);
      chk("PCD",      bus.PCD_o,       e.pcd);
      chk("PCPlus4D", bus.PCPlus4D_o,  e.pcp4d);
      chk("ValidD",   32'(bus.ValidD_o), 32'(e.vd));
      chk("ValidE",   32'(bus.ValidE_o), 32'(e.ve));
      chk("CtrlE",    32'(bus.CtrlE_o),  32'(e.ctrle));
      chk("RSE",      32'(bus.RS_addrE_o), 32'(e.rs));
      chk("RTE",      32'(bus.RT_addrE_o), 32'(e.rt));
      chk("RDE",      32'(bus.RD_addrE_o), 32'(e.rd));
      chk("RD1E",     bus.RD1E_o,      e.rd1);
      chk("RD2E",     bus.RD2E_o,      e.rd2);
      chk("ImmE",     bus.ImmExtE_o,   e.imm);
      chk("PCE",      bus.PCE_o,       e.pce);
      chk("PCPlus4E", bus.PCPlus4E_o,  e.pcp4e);
      chk("StallCnt", bus.StallCnt_o,  e.scnt);
      chk("FlushCnt", bus.FlushCnt_o,  e.fcnt);
      chk("StallCnt4", 32'(bus4.StallCnt_o), 32'(e.scnt4));
      chk("FlushCnt4", 32'(bus4.FlushCnt_o), 32'(e.fcnt4));
      chk("PCF_w4",   bus4.PCF_o,      e.pcf);
   endtask

   // One clock: drive at the falling edge, predict, compare just after the rising edge.
   task automatic step(input bit stf, input bit std, input bit fd, input bit fe,
                       input bit src, input logic [31:0] tgt, input logic [31:0] instr);
      exp_t n;
      exp_t e;
      @(negedge clk);
      if (release_pending) begin
         rst_n = 1'b1;
         release_pending = 1'b0;
      end
      bus.StallF_i     = stf;
      bus.StallD_i     = std;
      bus.FlushD_i     = fd;
      bus.FlushE_i     = fe;
      bus.PC_SrcE_i    = src;
      bus.PC_TargetE_i = tgt;
      bus.InstrF_i     = instr;
      bus.CtrlD_i      = 10'($urandom);
      bus.RD1D_i       = $urandom;
      bus.RD2D_i       = $urandom;
      bus.ImmExtD_i    = $urandom;
      bus.RS_addrD_i   = 5'($urandom);
      bus.RT_addrD_i   = 5'($urandom);
      bus.RD_addrD_i   = 5'($urandom);

      n = m;
      if (src)       n.pcf = tgt;
      else if (!stf) n.pcf = m.pcf + 32'd4;
      if (fd) begin
         n.instrd = NOP_INSTR; n.pcd = '0; n.pcp4d = '0; n.vd = 1'b0;
      end else if (!std) begin
         n.instrd = instr; n.pcd = m.pcf; n.pcp4d = m.pcf + 32'd4; n.vd = 1'b1;
      end
      if (fe) begin
         n.ctrle = '0; n.rs = '0; n.rt = '0; n.rd = '0; n.rd1 = '0; n.rd2 = '0;
         n.imm = '0; n.pce = '0; n.pcp4e = '0; n.ve = 1'b0;
      end else begin
         n.ctrle = bus.CtrlD_i; n.rs = bus.RS_addrD_i; n.rt = bus.RT_addrD_i;
         n.rd = bus.RD_addrD_i; n.rd1 = bus.RD1D_i; n.rd2 = bus.RD2D_i;
         n.imm = bus.ImmExtD_i; n.pce = m.pcd; n.pcp4e = m.pcp4d; n.ve = m.vd;
      end
      if ((stf || std) && m.scnt  != 32'hFFFF_FFFF) n.scnt  = m.scnt + 32'd1;
      if ((fd  || fe ) && m.fcnt  != 32'hFFFF_FFFF) n.fcnt  = m.fcnt + 32'd1;
      if ((stf || std) && m.scnt4 != 4'hF)          n.scnt4 = m.scnt4 + 4'd1;
      if ((fd  || fe ) && m.fcnt4 != 4'hF)          n.fcnt4 = m.fcnt4 + 4'd1;
      q.push_back(n);
      m = n;

      @(posedge clk);
      #1;
      if (q.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
      else begin
         e = q.pop_front();
         check_all(e);
      end
   endtask

   initial begin
      logic [31:0] pc_hold;
      logic [31:0] instr_hold;
      bus.StallF_i = 0; bus.StallD_i = 0; bus.FlushD_i = 0; bus.FlushE_i = 0;
      bus.PC_SrcE_i = 0; bus.PC_TargetE_i = '0; bus.InstrF_i = '0;
      bus.CtrlD_i = '0; bus.RD1D_i = '0; bus.RD2D_i = '0; bus.ImmExtD_i = '0;
      bus.RS_addrD_i = '0; bus.RT_addrD_i = '0; bus.RD_addrD_i = '0;

      // Reset state, with a redirect pending on the inputs that must be ignored
      bus.PC_SrcE_i = 1'b1; bus.PC_TargetE_i = 32'h0000_0400; bus.StallF_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_model();
      check_all(m);

      // T1: four free-running cycles
      release_pending = 1'b1;
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, '0, 32'h1000_0000 + 32'(i));
      chk("T1_pcf16", bus.PCF_o, 32'd16);
      chk("T1_instrd", bus.InstrD_o, 32'h1000_0003);

      // T2: load-use stall with ID/EX bubble
      pc_hold = m.pcf; instr_hold = m.instrd;
      step(1, 1, 0, 1, 0, '0, 32'hDEAD_BEEF);
      chk("T2_pcf_hold", bus.PCF_o, pc_hold);
      chk("T2_instrd_hold", bus.InstrD_o, instr_hold);
      chk("T2_ctrle", 32'(bus.CtrlE_o), 32'd0);
      chk("T2_stallcnt", bus.StallCnt_o, 32'd1);
      chk("T2_flushcnt", bus.FlushCnt_o, 32'd1);
      step(0, 0, 0, 0, 0, '0, 32'h2000_0000);

      // T3: taken branch
      step(0, 0, 1, 1, 1, 32'h100, 32'h3000_0000);
      chk("T3_pcf", bus.PCF_o, 32'h100);
      chk("T3_instrd", bus.InstrD_o, 32'h13);
      chk("T3_validd", 32'(bus.ValidD_o), 32'd0);
      chk("T3_valide", 32'(bus.ValidE_o), 32'd0);
      step(0, 0, 0, 0, 0, '0, 32'h3000_0001);
      step(0, 0, 0, 0, 0, '0, 32'h3000_0002);

      // T4: redirect wins over StallF
      step(1, 0, 0, 0, 1, 32'h200, 32'h4000_0000);
      chk("T4_pcf", bus.PCF_o, 32'h200);

      // T5: PC wraps to zero
      step(0, 0, 1, 1, 1, 32'hFFFF_FFFC, 32'h5000_0000);
      step(0, 0, 0, 0, 0, '0, 32'h5000_0001);
      chk("T5_wrap", bus.PCF_o, 32'h0);
      step(0, 0, 0, 0, 0, '0, 32'h5000_0002);
      chk("T5_pcd_top", bus.PCD_o, 32'h0);

      // T6: counter saturation, then reset in the middle of a cycle
      for (int i = 0; i < 20; i++) step(1, 1, 0, 1, 0, '0, 32'h6000_0000);
      chk("T6_sat4", 32'(bus4.StallCnt_o), 32'hF);
      bus.PC_SrcE_i = 1'b1; bus.PC_TargetE_i = 32'h300; bus.FlushD_i = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      reset_model();
      check_all(m);
      @(posedge clk);
      #1;
      chk("T6_rst_hold_pcf", bus.PCF_o, RESET_PC);
      release_pending = 1'b1;
      step(0, 0, 0, 0, 0, '0, 32'h7000_0000);
      step(0, 0, 0, 0, 0, '0, 32'h7000_0001);
      chk("T6_post_pcf", bus.PCF_o, 32'd8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
